// File: rtl/if_fetch_ctrl_pkg.sv
// if_fetch_ctrl_pkg
//   Shared constants, bus widths and FSM state encoding for the instruction
//   fetch sequencer. Every if_fetch_* file imports this package.
package if_fetch_ctrl_pkg;

   localparam logic RST_ENABLE   = 1'b1;
   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;

   typedef logic [INST_ADDR_W-1:0] inst_addr_t;
   typedef logic [INST_W-1:0]      inst_t;

   localparam inst_t ZERO_WORD = '0;

   typedef enum logic [1:0] {
      IF_IDLE  = 2'd0,
      IF_FETCH = 2'd1,
      IF_HOLD  = 2'd2,
      IF_ERR   = 2'd3
   } if_state_e;

   // Instructions are word aligned; the low two address bits are always zero.
   function automatic inst_addr_t align_word(input inst_addr_t a);
      return {a[INST_ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// if_fetch_ctrl_if
//   Instruction-memory request/ack bus.
//   req   : request, held until ack
//   addr  : request address, stable while req is high and ack is low
//   ack   : read data valid this cycle, completes the request
//   rdata : read data
//   master = fetch sequencer, slave = instruction memory.
interface if_fetch_ctrl_if;
   import if_fetch_ctrl_pkg::*;

   logic       req;
   inst_addr_t addr;
   logic       ack;
   inst_t      rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_timer.sv
// if_fetch_timer
//   Counts consecutive cycles a fetch request waits for its ack. The count
//   restarts whenever the wait is broken (ack arrives or req drops), so each
//   new request starts from zero.
//   clk, rst  : clock, synchronous active-high reset
//   wait_i    : request outstanding and not acknowledged this cycle
//   expired_o : this is the TIMEOUT_CYC-th consecutive wait cycle
module if_fetch_timer
   import if_fetch_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic wait_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = wait_i ? cnt_q + 1'b1 : '0;
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) cnt_q <= '0;
      else                   cnt_q <= cnt_d;
   end

   assign expired_o = wait_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl
//   Instruction-fetch sequencer. Owns pc/ce, runs a req/ack handshake to the
//   instruction memory, absorbs wait states, and feeds the IF/ID register
//   with stall back-pressure and branch redirects from ID.
//   Optional feature macro: FETCH_TIMEOUT_EN (request timeout -> ERR state).
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   stall_i          : IF/ID cannot accept; output register holds
//   branch_flag_i    : one-cycle redirect pulse
//   branch_target_i  : redirect address (low two bits ignored)
//   imem             : instruction memory bus (master side)
//   pc               : next fetch address
//   ce               : fetch enable
//   inst_o/inst_pc_o : instruction and its address for IF/ID
//   inst_valid_o     : inst_o valid; consumed when valid & !stall_i
//   fetch_err_o      : fetch timeout flag (0 without FETCH_TIMEOUT_EN)
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter inst_addr_t RESET_PC    = 32'h0000_0000,
   parameter int         TIMEOUT_CYC = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_i,
   input  logic                   branch_flag_i,
   input  inst_addr_t             branch_target_i,
   if_fetch_ctrl_if.master        imem,
   output inst_addr_t             pc,
   output logic                   ce,
   output inst_t                  inst_o,
   output inst_addr_t             inst_pc_o,
   output logic                   inst_valid_o,
   output logic                   fetch_err_o
);

   if_state_e  state_q, state_d;
   inst_addr_t pc_q, pc_d;
   inst_addr_t addr_q, addr_d;
   logic       ce_q, ce_d;
   logic       drop_q, drop_d;     // outstanding access belongs to a redirected path
   inst_t      hold_q, hold_d;     // instruction fetched while output was blocked
   inst_t      inst_q, inst_d;
   inst_addr_t ipc_q, ipc_d;
   logic       valid_q, valid_d;
   logic       out_free;
   logic       tmo_expired;

   assign out_free = !valid_q || !stall_i;

   // Request decoded straight from the state register; address comes from its
   // own register so it stays put while a redirect updates pc mid-access.
   assign imem.req  = (state_q == IF_FETCH);
   assign imem.addr = addr_q;

`ifdef FETCH_TIMEOUT_EN
   if_fetch_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .wait_i    (imem.req && !imem.ack),
      .expired_o (tmo_expired)
   );
   assign fetch_err_o = (state_q == IF_ERR);
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = (TIMEOUT_CYC == 0);
   assign tmo_expired    = 1'b0;
   assign fetch_err_o    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ce_d    = ce_q;
      drop_d  = drop_q;
      hold_d  = hold_q;
      inst_d  = inst_q;
      ipc_d   = ipc_q;
      // A consumed instruction empties the register unless something reloads it.
      valid_d = valid_q && stall_i;

      unique case (state_q)
         IF_IDLE: begin
            ce_d    = CHIP_ENABLE;
            state_d = IF_FETCH;
         end
         IF_FETCH: begin
            if (branch_flag_i) begin
               pc_d   = align_word(branch_target_i);
               // An ack this cycle is simply discarded; otherwise the access
               // in flight must still complete before the new pc goes out.
               drop_d = !imem.ack;
            end else if (imem.ack) begin
               if (drop_q) begin
                  drop_d = 1'b0;
               end else if (out_free) begin
                  inst_d  = imem.rdata;
                  ipc_d   = pc_q;
                  valid_d = 1'b1;
                  pc_d    = pc_q + 32'd4;
               end else begin
                  hold_d  = imem.rdata;
                  state_d = IF_HOLD;
               end
            end else if (tmo_expired) begin
               state_d = IF_ERR;
            end
         end
         IF_HOLD: begin
            if (branch_flag_i) begin
               pc_d    = align_word(branch_target_i);
               state_d = IF_FETCH;
            end else if (out_free) begin
               inst_d  = hold_q;
               ipc_d   = pc_q;
               valid_d = 1'b1;
               pc_d    = pc_q + 32'd4;
               state_d = IF_FETCH;
            end
         end
         IF_ERR: begin
            // Only a redirect (exception vector) leaves ERR; late acks are ignored.
            if (branch_flag_i) begin
               pc_d    = align_word(branch_target_i);
               drop_d  = 1'b0;
               state_d = IF_FETCH;
            end
         end
         default: state_d = IF_IDLE;
      endcase

      addr_d = (imem.req && !imem.ack) ? addr_q : pc_d;
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q <= IF_IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         ce_q    <= CHIP_DISABLE;
         drop_q  <= 1'b0;
         hold_q  <= ZERO_WORD;
         inst_q  <= ZERO_WORD;
         ipc_q   <= ZERO_WORD;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         ce_q    <= ce_d;
         drop_q  <= drop_d;
         hold_q  <= hold_d;
         inst_q  <= inst_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
      end
   end

   assign pc           = pc_q;
   assign ce           = ce_q;
   assign inst_o       = inst_q;
   assign inst_pc_o    = ipc_q;
   assign inst_valid_o = valid_q;

endmodule
